fifo_push_arb: RTL and testbench

Packet-atomic round-robin arbiter that lets `N_REQ` producers share the write port of one `std_fifo` instance. Grants are held for a whole packet, delimited by a `last` flag, so beats from different requesters never interleave in the FIFO. It sits directly in front of the FIFO: it drives the FIFO's `push` and `d` and consumes its `full` and `almost_full`.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_push_arb.sv | 117 +++++++++++
 tb/tb_fifo_push_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO push arbiter.
//   arb_state_t : arbiter FSM state (StIdle = 0, StBurst = 1)
//   StatW       : width of each per-requester packet counter
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_t;

  localparam int unsigned StatW = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Finds the first set bit of req searching upward from ptr, wrapping at N.
// Ports:
//   req   in  [N-1:0]   request vector
//   ptr   in  [IDW-1:0] index with highest priority (must be < N)
//   found out           at least one request is set
//   idx   out [IDW-1:0] winning index (0 when found is low)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [31:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: packet-atomic round-robin arbiter for the write port of a FIFO.
// A grant is held from the first beat of a packet until its last beat is
// accepted, so packets from different requesters never interleave.
// Optional feature: define FIFO_ARB_STATS_EN to add per-requester packet
// counters on stat_pkts.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req/last/data      per-requester beat valid, end-of-packet, beat payload
//   ack                per-requester beat accepted this cycle (one-hot or 0)
//   fifo_push, fifo_d  to FIFO push / d
//   fifo_full          from FIFO full (stalls the current owner)
//   fifo_almost_full   from FIFO almost_full (gates new grants only)
//   owner, busy        current grant holder, grant active
//   stat_pkts          (FIFO_ARB_STATS_EN) completed packets, 16 bits each
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic                   fifo_push,
  output logic [WIDTH-1:0]       fifo_d,
  input  logic                   fifo_full,
  input  logic                   fifo_almost_full,
  output logic [IDW-1:0]         owner,
  output logic                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*StatW-1:0] stat_pkts
`endif
);

  arb_state_t     state;
  logic [IDW-1:0] rr;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] rr_next;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (rr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Priority moves to the requester after the one that just finished.
  assign rr_next = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // rst gates ack so an abandoned packet pushes nothing in the reset cycle.
  always_comb begin
    ack = '0;
    if (state == StBurst && !rst) begin
      ack[owner] = req[owner] & ~fifo_full;
    end
  end

  assign fifo_push = |ack;
  assign fifo_d    = data[owner*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      rr    <= '0;
      owner <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          // New packets start only when the FIFO has headroom.
          if (pick_found && !fifo_almost_full) begin
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= StBurst;
          end
        end
        StBurst: begin
          if (ack[owner] && last[owner]) begin
            busy  <= 1'b0;
            rr    <= rr_next;
            state <= StIdle;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [StatW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (ack[i] && last[i] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stat_pkts[i*StatW +: StatW] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed self-checking bench for fifo_push_arb
// (N_REQ=4, WIDTH=8). Inputs change 1ns after a rising edge; outputs are
// checked on the falling edge.
module tb_fifo_push_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        fifo_push;
  logic [7:0]  fifo_d;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic [1:0]  owner;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] stat_pkts;
`endif

  int total = 0;
  int bad   = 0;
  int beat[4];
  logic [3:0] ackv;

  always #5 clk = ~clk;

  fifo_push_arb #(
    .N_REQ (4),
    .WIDTH (8),
    .IDW   (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .last             (last),
    .data             (data),
    .ack              (ack),
    .fifo_push        (fifo_push),
    .fifo_d           (fifo_d),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .owner            (owner),
    .busy             (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_pkts        (stat_pkts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pc();
    @(posedge clk);
    #1;
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    last = '0;
    data = '0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    for (int i = 0; i < 4; i++) beat[i] = 0;

    // 1. Reset values, then idle with no requests
    pc();
    pc();
    nc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_push", 32'(fifo_push), 0);
    pc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nc();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_push", 32'(fifo_push), 0);
      pc();
    end

    // 2. Fairness: four requesters, continuous 2-beat packets
    for (int k = 0; k < 24; k++) begin
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        data[i*8 +: 8] = 8'(8'h10 * i + beat[i]);
        last[i] = (beat[i] == 1);
      end
      nc();
      if (k % 3 == 0) begin
        chk("rr_gap_ack", 32'(ack), 0);
        chk("rr_gap_push", 32'(fifo_push), 0);
        chk("rr_gap_busy", 32'(busy), 0);
      end else begin
        chk("rr_owner", 32'(owner), (k / 3) % 4);
        chk("rr_ack", 32'(ack), 1 << ((k / 3) % 4));
        chk("rr_push", 32'(fifo_push), 1);
        chk("rr_d", 32'(fifo_d), 8'h10 * ((k / 3) % 4) + (k % 3) - 1);
      end
      ackv = ack;
      pc();
      for (int i = 0; i < 4; i++) if (ackv[i]) beat[i] = beat[i] ^ 1;
    end
    req = '0;
    last = '0;

    // 3. Backpressure mid-packet from requester 2 (rr is 0 here)
    req = 4'b0100;
    data[23:16] = 8'hA0;
    nc();
    chk("bp_idle_busy", 32'(busy), 0);
    pc();
    nc();
    chk("bp_owner", 32'(owner), 2);
    chk("bp_ack0", 32'(ack), 4'b0100);
    chk("bp_d0", 32'(fifo_d), 8'hA0);
    pc();
    data[23:16] = 8'hA1;
    fifo_full = 1'b1;
    fifo_almost_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      nc();
      chk("bp_full_ack", 32'(ack), 0);
      chk("bp_full_push", 32'(fifo_push), 0);
      chk("bp_full_owner", 32'(owner), 2);
      chk("bp_full_busy", 32'(busy), 1);
      pc();
    end
    fifo_full = 1'b0;
    nc();
    chk("bp_af_ignored_ack", 32'(ack), 4'b0100);
    chk("bp_d1", 32'(fifo_d), 8'hA1);
    pc();
    fifo_almost_full = 1'b0;
    data[23:16] = 8'hA2;
    last = 4'b0100;
    nc();
    chk("bp_last_push", 32'(fifo_push), 1);
    chk("bp_d2", 32'(fifo_d), 8'hA2);
    pc();
    req = '0;
    last = '0;
    nc();
    chk("bp_done_busy", 32'(busy), 0);

    // 4. Headroom gate in IDLE (rr is 3 here)
    req = 4'b0010;
    last = 4'b0010;
    data[15:8] = 8'h5B;
    fifo_almost_full = 1'b1;
    nc();
    chk("af_ack", 32'(ack), 0);
    pc();
    nc();
    chk("af_busy1", 32'(busy), 0);
    pc();
    nc();
    chk("af_busy2", 32'(busy), 0);
    chk("af_push", 32'(fifo_push), 0);
    fifo_almost_full = 1'b0;
    pc();
    nc();
    chk("af_grant_busy", 32'(busy), 1);
    chk("af_grant_owner", 32'(owner), 1);
    chk("af_grant_ack", 32'(ack), 4'b0010);
    chk("af_grant_d", 32'(fifo_d), 8'h5B);
    pc();
    req = '0;
    last = '0;
    nc();
    chk("af_done_busy", 32'(busy), 0);

    // 5. Reset during beat 3 of a 6-beat packet from requester 3 (rr is 2)
    req = 4'b1000;
    data[31:24] = 8'hC0;
    pc();
    nc();
    chk("mr_owner", 32'(owner), 3);
    chk("mr_d0", 32'(fifo_d), 8'hC0);
    pc();
    data[31:24] = 8'hC1;
    nc();
    chk("mr_push1", 32'(fifo_push), 1);
    pc();
    data[31:24] = 8'hC2;
    rst = 1'b1;
    nc();
    chk("mr_rst_ack", 32'(ack), 0);
    chk("mr_rst_push", 32'(fifo_push), 0);
    pc();
    rst = 1'b0;
    req = 4'b1001;
    last = 4'b1001;
    data[7:0] = 8'h0F;
    nc();
    chk("mr_after_busy", 32'(busy), 0);
    pc();
    nc();
    chk("mr_rr0_owner", 32'(owner), 0);
    chk("mr_rr0_busy", 32'(busy), 1);
    chk("mr_rr0_d", 32'(fifo_d), 8'h0F);
    pc();
    req = '0;
    last = '0;
    nc();
    chk("mr_end_busy", 32'(busy), 0);

`ifdef FIFO_ARB_STATS_EN
    // 6. Saturating packet counters
    pc();
    rst = 1'b1;
    pc();
    rst = 1'b0;
    req = 4'b0010;
    last = 4'b0010;
    for (int c = 0; c < 140000; c++) @(posedge clk);
    #1;
    req = '0;
    last = '0;
    nc();
    chk("stat_r0", 32'(stat_pkts[15:0]), 0);
    chk("stat_r1_sat", 32'(stat_pkts[31:16]), 16'hFFFF);
    chk("stat_r2", 32'(stat_pkts[47:32]), 0);
    chk("stat_r3", 32'(stat_pkts[63:48]), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
